// File: rtl/montador_de_digitos.sv
// Turns the keypad decoder's held key level into single key events and assembles
// up to DIGITS BCD digits, with backspace (*), confirm (#) and an inactivity timeout.
module montador_de_digitos #(
   parameter int DIGITS  = 4,
   parameter int TIMEOUT = 50_000_000
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [3:0]                         tecla_value,
   input  logic                               tecla_valid,
   output logic [4*DIGITS-1:0]                buffer_digitos,
   output logic [$clog2(DIGITS+1)-1:0]        qtd_digitos,
   output logic [4*DIGITS-1:0]                numero,
   output logic                               numero_valid,
   output logic                               erro,
   output logic                               expirou
);

   localparam int W  = 4 * DIGITS;
   localparam int QW = $clog2(DIGITS + 1);
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {VAZIO, ENTRADA, CHEIO} state_t;

   state_t         state_q, state_d;
   logic [W-1:0]   digitBuf_q, digitBuf_d;
   logic [W-1:0]   numero_q, numero_d;
   logic [QW-1:0]  count_q, count_d;
   logic [TW-1:0]  timer_q, timer_d;
   logic           validDly_q;
   logic           numValid_q, numValid_d;
   logic           erro_q, erro_d;
   logic           expirou_q, expirou_d;

   logic           keyEvent;
   logic [QW-1:0]  countInc;
   logic [QW-1:0]  countDec;

   assign keyEvent = tecla_valid && !validDly_q;
   assign countInc = count_q + QW'(1);
   assign countDec = count_q - QW'(1);

   // validDly_q resets high so a key still held when reset releases is not taken as a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= VAZIO;
         digitBuf_q <= '0;
         numero_q   <= '0;
         count_q    <= '0;
         timer_q    <= '0;
         validDly_q <= 1'b1;
         numValid_q <= 1'b0;
         erro_q     <= 1'b0;
         expirou_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         digitBuf_q <= digitBuf_d;
         numero_q   <= numero_d;
         count_q    <= count_d;
         timer_q    <= timer_d;
         validDly_q <= tecla_valid;
         numValid_q <= numValid_d;
         erro_q     <= erro_d;
         expirou_q  <= expirou_d;
      end
   end

   // A key event on the same edge as the timeout takes priority and restarts the idle timer.
   always_comb begin
      state_d    = state_q;
      digitBuf_d = digitBuf_q;
      numero_d   = numero_q;
      count_d    = count_q;
      timer_d    = (state_q == VAZIO) ? '0 : timer_q + TW'(1);
      numValid_d = 1'b0;
      erro_d     = 1'b0;
      expirou_d  = 1'b0;

      if (keyEvent) begin
         timer_d = '0;
         if (tecla_value <= 4'd9) begin
            if (state_q == CHEIO) begin
               erro_d = 1'b1;
            end else begin
               digitBuf_d = (digitBuf_q << 4) | W'(tecla_value);
               count_d    = countInc;
               state_d    = (countInc == QW'(DIGITS)) ? CHEIO : ENTRADA;
            end
         end else if (tecla_value == 4'hE) begin
            if (state_q != VAZIO) begin
               digitBuf_d = digitBuf_q >> 4;
               count_d    = countDec;
               state_d    = (countDec == '0) ? VAZIO : ENTRADA;
            end
         end else if (tecla_value == 4'hF) begin
            if (state_q == VAZIO) begin
               erro_d = 1'b1;
            end else begin
               numero_d   = digitBuf_q;
               numValid_d = 1'b1;
               digitBuf_d = '0;
               count_d    = '0;
               state_d    = VAZIO;
            end
         end else begin
            erro_d = 1'b1;
         end
      end else if ((state_q != VAZIO) && (timer_q == TW'(TIMEOUT - 1))) begin
         digitBuf_d = '0;
         count_d    = '0;
         state_d    = VAZIO;
         expirou_d  = 1'b1;
         timer_d    = '0;
      end
   end

   always_comb begin
      buffer_digitos = digitBuf_q;
      qtd_digitos    = count_q;
      numero         = numero_q;
      numero_valid   = numValid_q;
      erro           = erro_q;
      expirou        = expirou_q;
   end

endmodule

// File: tb/tb_montador_de_digitos.sv
// Directed bench for montador_de_digitos with DIGITS=4, TIMEOUT=20 and hand-computed
// expected buffer, count and pulse values.
module tb_montador_de_digitos;

   localparam int DIGITS  = 4;
   localparam int TIMEOUT = 20;

   logic        clk;
   logic        rst;
   logic [3:0]  tecla_value;
   logic        tecla_valid;
   logic [15:0] buffer_digitos;
   logic [2:0]  qtd_digitos;
   logic [15:0] numero;
   logic        numero_valid;
   logic        erro;
   logic        expirou;

   int compared = 0;
   int mismatched = 0;

   montador_de_digitos #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
      .clk            (clk),
      .rst            (rst),
      .tecla_value    (tecla_value),
      .tecla_valid    (tecla_valid),
      .buffer_digitos (buffer_digitos),
      .qtd_digitos    (qtd_digitos),
      .numero         (numero),
      .numero_valid   (numero_valid),
      .erro           (erro),
      .expirou        (expirou)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Raise tecla_valid with a key code; returns just after the edge that samples the press.
   task automatic applyStimulus(input logic [3:0] key);
      @(negedge clk);
      tecla_value = key;
      tecla_valid = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic releaseKey();
      @(negedge clk);
      tecla_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic pressDigit(input logic [3:0] key);
      applyStimulus(key);
      releaseKey();
   endtask

   initial begin
      int n;
      int expCount;
      int expCycle;

      rst = 1'b1;
      tecla_value = 4'h0;
      tecla_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("reset buffer", buffer_digitos, 16'h0000);
      checkOutput("reset qtd", qtd_digitos, 3'd0);
      checkOutput("reset numero", numero, 16'h0000);
      checkOutput("reset pulses", {numero_valid, erro, expirou}, 3'b000);

      // 1, 2, 3 then # confirms 0x0123
      applyStimulus(4'h1);
      checkOutput("key1 buffer", buffer_digitos, 16'h0001);
      checkOutput("key1 qtd", qtd_digitos, 3'd1);
      releaseKey();
      applyStimulus(4'h2);
      checkOutput("key2 buffer", buffer_digitos, 16'h0012);
      releaseKey();
      applyStimulus(4'h3);
      checkOutput("key3 buffer", buffer_digitos, 16'h0123);
      checkOutput("key3 qtd", qtd_digitos, 3'd3);
      releaseKey();
      applyStimulus(4'hF);
      checkOutput("confirm numero", numero, 16'h0123);
      checkOutput("confirm pulses", {numero_valid, erro, expirou}, 3'b100);
      checkOutput("confirm buffer", buffer_digitos, 16'h0000);
      checkOutput("confirm qtd", qtd_digitos, 3'd0);
      releaseKey();
      checkOutput("confirm pulse width", numero_valid, 1'b0);
      checkOutput("numero held", numero, 16'h0123);

      // Key 7 held for 50 cycles: one event, then the idle timeout clears it once
      applyStimulus(4'h7);
      checkOutput("hold7 buffer", buffer_digitos, 16'h0007);
      checkOutput("hold7 qtd", qtd_digitos, 3'd1);
      expCount = 0;
      expCycle = 0;
      for (int i = 1; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (expirou) begin
            expCount++;
            expCycle = i;
         end
         if (i == 15) checkOutput("hold7 no repeat", buffer_digitos, 16'h0007);
      end
      checkOutput("hold7 expirou count", expCount, 1);
      checkOutput("hold7 expirou cycle", expCycle, TIMEOUT);
      checkOutput("hold7 final buffer", buffer_digitos, 16'h0000);
      checkOutput("hold7 final qtd", qtd_digitos, 3'd0);
      releaseKey();

      // Fill to 9876, reject the fifth digit, then backspace twice
      pressDigit(4'h9);
      pressDigit(4'h8);
      pressDigit(4'h7);
      applyStimulus(4'h6);
      checkOutput("full buffer", buffer_digitos, 16'h9876);
      checkOutput("full qtd", qtd_digitos, 3'd4);
      releaseKey();
      applyStimulus(4'h5);
      checkOutput("overflow pulses", {numero_valid, erro, expirou}, 3'b010);
      checkOutput("overflow buffer", buffer_digitos, 16'h9876);
      checkOutput("overflow qtd", qtd_digitos, 3'd4);
      releaseKey();
      checkOutput("overflow pulse width", erro, 1'b0);
      applyStimulus(4'hE);
      checkOutput("bksp1 buffer", buffer_digitos, 16'h0987);
      releaseKey();
      applyStimulus(4'hE);
      checkOutput("bksp2 buffer", buffer_digitos, 16'h0098);
      checkOutput("bksp2 qtd", qtd_digitos, 3'd2);
      releaseKey();
      applyStimulus(4'hF);
      checkOutput("confirm2 numero", numero, 16'h0098);
      releaseKey();

      // Rejections and the silent backspace in VAZIO
      applyStimulus(4'hF);
      checkOutput("empty confirm pulses", {numero_valid, erro, expirou}, 3'b010);
      checkOutput("empty confirm numero", numero, 16'h0098);
      releaseKey();
      pressDigit(4'h2);
      applyStimulus(4'hB);
      checkOutput("letter pulses", {numero_valid, erro, expirou}, 3'b010);
      checkOutput("letter buffer", buffer_digitos, 16'h0002);
      releaseKey();
      pressDigit(4'hE);
      applyStimulus(4'hE);
      checkOutput("empty bksp pulses", {numero_valid, erro, expirou}, 3'b000);
      checkOutput("empty bksp buffer", buffer_digitos, 16'h0000);
      releaseKey();

      // Timeout 20 edges after the event edge
      applyStimulus(4'h4);
      n = 0;
      while (!expirou && n < 40) begin
         @(negedge clk);
         tecla_valid = 1'b0;
         @(posedge clk);
         #1;
         n++;
      end
      checkOutput("timeout cycle", n, TIMEOUT);
      checkOutput("timeout pulses", {numero_valid, erro, expirou}, 3'b001);
      checkOutput("timeout buffer", buffer_digitos, 16'h0000);
      checkOutput("timeout qtd", qtd_digitos, 3'd0);
      @(posedge clk);
      #1;
      checkOutput("timeout pulse width", expirou, 1'b0);

      // Event on the would-be timeout edge wins
      applyStimulus(4'h4);
      releaseKey();
      repeat (TIMEOUT - 2) @(posedge clk);
      applyStimulus(4'h5);
      checkOutput("race buffer", buffer_digitos, 16'h0045);
      checkOutput("race qtd", qtd_digitos, 3'd2);
      checkOutput("race expirou", expirou, 1'b0);
      releaseKey();
      checkOutput("race expirou next", expirou, 1'b0);

      // Async reset mid-entry with the key still held through release
      pressDigit(4'hE);
      pressDigit(4'hE);
      pressDigit(4'h3);
      applyStimulus(4'h1);
      checkOutput("pre-reset buffer", buffer_digitos, 16'h0031);
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async reset buffer", buffer_digitos, 16'h0000);
      checkOutput("async reset qtd", qtd_digitos, 3'd0);
      checkOutput("async reset numero", numero, 16'h0000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      tecla_value = 4'h6;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("held through reset buffer", buffer_digitos, 16'h0000);
      checkOutput("held through reset qtd", qtd_digitos, 3'd0);
      releaseKey();
      applyStimulus(4'h6);
      checkOutput("repress buffer", buffer_digitos, 16'h0006);
      checkOutput("repress qtd", qtd_digitos, 3'd1);
      releaseKey();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
